spi_xfer_sched: RTL
===================

Name: spi_xfer_sched

Overview:
- Round-robin scheduler that shares one SPI master core between N_REQ requesters.
- Each granted requester gets an exclusive multi-byte frame with its own mode (cpol/cpha) and clock divider (dvsr).
- Drives the master's start/din/cpol/cpha/dvsr pins and one active-low slave select per requester.
- Returns each received byte to the owner and enforces CS setup/hold timing and a per-byte watchdog.

Parameters:
- N_REQ, 2, number of requesters and slave selects.
- LEN_W, 4, width of the frame byte-count field.
- DVSR_W, 16, width of the SPI clock divider.
- SETUP_CYC, 4, clk_i cycles from ss_n assertion to first start pulse.
- HOLD_CYC, 4, clk_i cycles from last done tick to ss_n deassertion.
- TIMEOUT, 1024, max clk_i cycles waiting for spi_done_tick_i per byte.

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- req_i  in  N_REQ  per-requester frame request, level; held until xfer_done_o.
- len_i  in  N_REQ*LEN_W  per-requester frame length in bytes; 0 encodes 2**LEN_W.
- cpol_i  in  N_REQ  per-requester clock polarity.
- cpha_i  in  N_REQ  per-requester clock phase.
- dvsr_i  in  N_REQ*DVSR_W  per-requester clock divider.
- tx_data_i  in  N_REQ*8  per-requester next TX byte.
- tx_valid_i  in  N_REQ  TX byte valid.
- tx_ready_o  out  N_REQ  TX byte accepted this cycle (one-hot or zero).
- rx_data_o  out  8  received byte, shared bus.
- rx_valid_o  out  N_REQ  one-cycle pulse to the owner of rx_data_o.
- gnt_o  out  N_REQ  one-hot grant, high for the whole frame.
- xfer_done_o  out  N_REQ  one-cycle frame-complete pulse.
- err_o  out  N_REQ  one-cycle watchdog-abort pulse.
- ss_n_o  out  N_REQ  active-low slave selects.
- spi_start_o  out  1  one-cycle start pulse to the master.
- spi_din_o  out  8  TX byte to the master, stable from start until done.
- spi_cpol_o / spi_cpha_o  out  1 each  mode to the master.
- spi_dvsr_o  out  DVSR_W  divider to the master.
- spi_dout_i  in  8  master RX byte.
- spi_done_tick_i  in  1  master byte-complete pulse.

Behaviour:
- Reset: all outputs 0, except ss_n_o = all ones. State IDLE, rr_ptr = 0.
- FSM states: IDLE, SETUP, LOAD, START, WAIT, HOLD, GAP.
- IDLE: if any req_i, grant the first set bit searching from rr_ptr upward with wrap. In the same cycle, latch len/cpol/cpha/dvsr of the winner and register gnt_o. Then assert its ss_n_o bit and go to SETUP. spi_cpol_o/cpha_o/dvsr_o update at grant and are stable for the whole frame, including while ss_n is high before SETUP ends.
- SETUP: count SETUP_CYC cycles, then go to LOAD.
- LOAD: assert tx_ready_o[gnt] while tx_valid_i[gnt] is low. On the valid&&ready cycle, register the byte into spi_din_o and go to START. A missing valid stalls indefinitely; the watchdog does not run in LOAD.
- START: spi_start_o = 1 for exactly one cycle, then WAIT.
- WAIT: on spi_done_tick_i, register spi_dout_i into rx_data_o and pulse rx_valid_o[gnt] the next cycle.
  - If bytes remain, decrement the counter and go to LOAD. No re-setup; ss_n stays low.
  - Otherwise go to HOLD.
  - If TIMEOUT cycles elapse with no tick: pulse err_o[gnt], skip remaining bytes, go to HOLD.
- HOLD: count HOLD_CYC cycles, then deassert ss_n and go to GAP.
- GAP: one cycle with no grant. Pulse xfer_done_o[gnt] (suppressed if aborted), clear gnt_o, set rr_ptr = gnt+1 mod N_REQ, go to IDLE. Minimum idle ss_n high time is 2 cycles.
- Arbitration is sampled only in IDLE. req_i dropping mid-frame is ignored and the frame completes.
- A done tick outside WAIT is ignored.
- Byte counter width is LEN_W+1. len 0 yields 2**LEN_W bytes.
- Async reset mid-frame: ss_n_o returns high immediately, spi_start_o low, with no done/err pulse.

Decomposition:
- spi_sched_pkg: state_t enum, localparams for counter widths ($clog2 of SETUP_CYC, HOLD_CYC, TIMEOUT).
- Sub-module rr_arbiter (N_REQ param; req, ptr -> one-hot gnt), combinational, reusable.

Test Plan:
- Single requester 0: dvsr=9, cpol=0, cpha=0, len=6, bytes 0x00..0x05; bench drives miso with the running sum of the previous and current byte -> six spi_start_o pulses, rx bytes 0x00,0x01,0x03,0x05,0x07,0x09, one xfer_done_o[0], ss_n_o[0] low for the whole frame.
- Both req_i high from reset, len=1 each, five rounds -> grants alternate 0,1,0,1,0; never two ss_n low together.
- Timing: SETUP_CYC=4, HOLD_CYC=4 -> exactly 4 cycles from ss_n fall to start pulse, 4 cycles from last done tick to ss_n rise.
- Per-requester config: req1 cpol=1, cpha=1, dvsr=3 after req0 cpol=0, dvsr=9 -> spi_* pins switch only at the grant cycle.
- Watchdog: suppress spi_done_tick_i, TIMEOUT=1024 -> err_o pulse at cycle 1024 of WAIT, no xfer_done_o, ss_n high after HOLD.
- Reset asserted in WAIT -> ss_n_o all ones and gnt_o 0 asynchronously; next request gets a fresh SETUP.

Source files
------------

// File: rtl/spi_sched_pkg.sv
// spi_sched_pkg: shared types and sizing helpers for the SPI transfer scheduler.
//   state_t  - scheduler FSM encoding
//   cnt_w()  - counter width for a count of n (never below 1 bit)
//   *_D      - default timing constants used by spi_xfer_sched
package spi_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_LOAD, S_START, S_WAIT, S_HOLD, S_GAP
  } state_t;

  localparam int SETUP_CYC_D = 4;
  localparam int HOLD_CYC_D  = 4;
  localparam int TIMEOUT_D   = 1024;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   i_req - request vector
//   i_ptr - index with highest priority this round
//   o_gnt - one-hot grant (zero when no request)
//   o_idx - binary index of the grant
//   o_any - at least one request present
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  int w_j;

  // Walk from i_ptr upward with wrap; first hit wins.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= N_REQ) w_j = w_j - N_REQ;
      if (!o_any && i_req[w_j]) begin
        o_gnt[w_j] = 1'b1;
        o_idx      = IDX_W'(w_j);
        o_any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_xfer_sched.sv
// spi_xfer_sched: shares one SPI master between N_REQ requesters, round robin.
// A granted requester owns a whole multi-byte frame: its cpol/cpha/dvsr are
// driven to the master from the grant cycle, its slave select is held low,
// bytes are pulled through tx_ready/tx_valid and returned on rx_data/rx_valid.
// Ports:
//   clk_i, reset_i              clock, async active-high reset
//   req_i/len_i/cpol_i/cpha_i/dvsr_i  per-requester frame request + config
//   tx_data_i/tx_valid_i/tx_ready_o   per-requester TX byte handshake
//   rx_data_o/rx_valid_o        shared RX byte, pulse to the owner
//   gnt_o/xfer_done_o/err_o     frame grant, completion, watchdog abort
//   ss_n_o                      active-low slave selects
//   spi_*                       master core interface
// Timing: ss_n fall to start pulse is SETUP_CYC edges when the TX byte is
// already valid (the LOAD handshake cycle is the last setup cycle, so
// SETUP_CYC must be >= 2); last done tick to ss_n rise is HOLD_CYC edges.
module spi_xfer_sched
  import spi_sched_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int LEN_W     = 4,
  parameter int DVSR_W    = 16,
  parameter int SETUP_CYC = SETUP_CYC_D,
  parameter int HOLD_CYC  = HOLD_CYC_D,
  parameter int TIMEOUT   = TIMEOUT_D
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*LEN_W-1:0]  len_i,
  input  logic [N_REQ-1:0]        cpol_i,
  input  logic [N_REQ-1:0]        cpha_i,
  input  logic [N_REQ*DVSR_W-1:0] dvsr_i,
  input  logic [N_REQ*8-1:0]      tx_data_i,
  input  logic [N_REQ-1:0]        tx_valid_i,
  output logic [N_REQ-1:0]        tx_ready_o,
  output logic [7:0]              rx_data_o,
  output logic [N_REQ-1:0]        rx_valid_o,
  output logic [N_REQ-1:0]        gnt_o,
  output logic [N_REQ-1:0]        xfer_done_o,
  output logic [N_REQ-1:0]        err_o,
  output logic [N_REQ-1:0]        ss_n_o,
  output logic                    spi_start_o,
  output logic [7:0]              spi_din_o,
  output logic                    spi_cpol_o,
  output logic                    spi_cpha_o,
  output logic [DVSR_W-1:0]       spi_dvsr_o,
  input  logic [7:0]              spi_dout_i,
  input  logic                    spi_done_tick_i
);

  localparam int IDX_W = cnt_w(N_REQ);
  localparam int TMR_W = cnt_w(TIMEOUT + SETUP_CYC + HOLD_CYC);
  localparam int CNT_W = LEN_W + 1;

  state_t            r_state;
  logic [IDX_W-1:0]  r_ptr, r_idx;
  logic [TMR_W-1:0]  r_tmr;
  logic [CNT_W-1:0]  r_left;
  logic              r_abort;
  logic [N_REQ-1:0]  r_gnt, r_ss_n, r_tx_rdy, r_rx_vld, r_done, r_err;
  logic [7:0]        r_rx_data, r_din;
  logic              r_start, r_cpol, r_cpha;
  logic [DVSR_W-1:0] r_dvsr;

  logic [N_REQ-1:0]  w_gnt;
  logic [IDX_W-1:0]  w_idx;
  logic              w_any;
  logic [LEN_W-1:0]  w_len;
  logic [7:0]        w_tx_byte;
  logic              w_tx_vld;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
    .i_req (req_i),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_len     = len_i[w_idx*LEN_W +: LEN_W];
  assign w_tx_byte = tx_data_i[r_idx*8 +: 8];
  assign w_tx_vld  = tx_valid_i[r_idx];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_idx     <= '0;
      r_tmr     <= '0;
      r_left    <= '0;
      r_abort   <= 1'b0;
      r_gnt     <= '0;
      r_ss_n    <= '1;
      r_tx_rdy  <= '0;
      r_rx_vld  <= '0;
      r_done    <= '0;
      r_err     <= '0;
      r_rx_data <= '0;
      r_din     <= '0;
      r_start   <= 1'b0;
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_dvsr    <= '0;
    end else begin
      // single-cycle pulses
      r_start  <= 1'b0;
      r_rx_vld <= '0;
      r_done   <= '0;
      r_err    <= '0;
      case (r_state)
        S_IDLE: if (w_any) begin
          r_gnt   <= w_gnt;
          r_idx   <= w_idx;
          r_ss_n  <= ~w_gnt;
          r_cpol  <= cpol_i[w_idx];
          r_cpha  <= cpha_i[w_idx];
          r_dvsr  <= dvsr_i[w_idx*DVSR_W +: DVSR_W];
          // len 0 means a full 2**LEN_W byte frame
          r_left  <= (w_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, w_len};
          r_abort <= 1'b0;
          r_tmr   <= TMR_W'(1);  // LOAD supplies the final setup cycle
          r_state <= S_SETUP;
        end
        S_SETUP: begin
          if (r_tmr == TMR_W'(SETUP_CYC - 1)) begin
            r_tx_rdy <= r_gnt;
            r_state  <= S_LOAD;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        S_LOAD: if (w_tx_vld) begin
          r_din    <= w_tx_byte;
          r_tx_rdy <= '0;
          r_start  <= 1'b1;
          r_state  <= S_START;
        end
        S_START: begin
          r_tmr   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (spi_done_tick_i) begin
            r_rx_data <= spi_dout_i;
            r_rx_vld  <= r_gnt;
            if (r_left == CNT_W'(1)) begin
              r_tmr   <= '0;
              r_state <= S_HOLD;
            end else begin
              r_left   <= r_left - 1'b1;
              r_tx_rdy <= r_gnt;
              r_state  <= S_LOAD;
            end
          end else if (r_tmr == TMR_W'(TIMEOUT - 1)) begin
            r_err   <= r_gnt;
            r_abort <= 1'b1;
            r_tmr   <= '0;
            r_state <= S_HOLD;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        S_HOLD: begin
          if (r_tmr == TMR_W'(HOLD_CYC - 1)) begin
            r_ss_n  <= '1;
            r_gnt   <= '0;
            r_done  <= r_abort ? '0 : r_gnt;
            r_ptr   <= (r_idx == IDX_W'(N_REQ - 1)) ? '0 : r_idx + 1'b1;
            r_state <= S_GAP;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        S_GAP:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt_o       = r_gnt;
  assign ss_n_o      = r_ss_n;
  assign tx_ready_o  = r_tx_rdy;
  assign rx_data_o   = r_rx_data;
  assign rx_valid_o  = r_rx_vld;
  assign xfer_done_o = r_done;
  assign err_o       = r_err;
  assign spi_start_o = r_start;
  assign spi_din_o   = r_din;
  assign spi_cpol_o  = r_cpol;
  assign spi_cpha_o  = r_cpha;
  assign spi_dvsr_o  = r_dvsr;

endmodule
